// File: rtl/prefix_sequencer.sv
// prefix_sequencer: absorbs x86 prefix bytes ahead of the decoder and presents the opcode byte
// Ports:
//   clk, reset (asynchronous, active-low)
//   flush (abort instruction), next_instruction (microcode end of instruction)
//   byte_valid / byte_in[7:0] / byte_ready           instruction byte stream
//   opcode_valid / opcode_out[7:0] / opcode_ready    opcode handshake to the decoder
//   so_update / so_segment_override / so_override[1:0]  strobes to the segment override unit
//   lock_prefix, rep_prefix[1:0], prefix_count[3:0], prefix_overflow  per-instruction prefix state
// Build option: define REP_PREFIX_EN to treat F2/F3 as REP prefixes; otherwise they are
//   ordinary opcodes and rep_prefix is tied to 00.
module prefix_sequencer #(
   parameter int MAX_PREFIX = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       flush,
   input  logic       next_instruction,
   input  logic       byte_valid,
   input  logic [7:0] byte_in,
   output logic       byte_ready,
   output logic       opcode_valid,
   output logic [7:0] opcode_out,
   input  logic       opcode_ready,
   output logic       so_update,
   output logic       so_segment_override,
   output logic [1:0] so_override,
   output logic       lock_prefix,
   output logic [1:0] rep_prefix,
   output logic [3:0] prefix_count,
   output logic       prefix_overflow
);
   localparam logic [1:0] COLLECT = 2'd0, OPCODE = 2'd1, EXEC = 2'd2;
   logic [1:0] r_state;
   logic [3:0] r_count;
   logic       r_lock, r_ovf;
   logic [7:0] r_op;
   logic       w_accept, w_seg, w_lock, w_rep, w_prefix, w_clear;
   logic [4:0] w_inc;
   assign byte_ready = (r_state == COLLECT) && !flush;
   assign w_accept = byte_valid && byte_ready;
   // 26/2E/36/3E share the pattern 001x_x110; bits [4:3] encode the segment
   assign w_seg = (byte_in[7:5] == 3'b001) && (byte_in[2:0] == 3'b110);
   assign w_lock = byte_in == 8'hF0;
`ifdef REP_PREFIX_EN
   assign w_rep = byte_in[7:1] == 7'b1111001;
`else
   assign w_rep = 1'b0;
`endif
   assign w_prefix = w_seg || w_lock || w_rep;
   assign w_clear = flush || (r_state == EXEC && next_instruction);
   // one extra bit so a saturated count of 15 still compares as exceeding the limit
   assign w_inc = {1'b0, r_count} + 5'd1;
   assign so_update = w_accept && w_seg;
   assign so_segment_override = so_update;
   assign so_override = so_update ? byte_in[4:3] : 2'b00;
   assign opcode_valid = r_state == OPCODE;
   assign opcode_out = r_op;
   assign lock_prefix = r_lock;
   assign prefix_count = r_count;
   assign prefix_overflow = r_ovf;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= COLLECT;
         r_op    <= 8'h00;
         r_count <= 4'd0;
         r_lock  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_clear) begin
            r_count <= 4'd0;
            r_lock  <= 1'b0;
            r_ovf   <= 1'b0;
         end else if (w_accept && w_prefix) begin
            r_count <= w_inc[4] ? 4'hF : w_inc[3:0];
            r_lock  <= r_lock || w_lock;
            r_ovf   <= r_ovf || (w_inc > 5'(MAX_PREFIX));
         end
         if (flush)
            r_state <= COLLECT;
         else if (w_accept && !w_prefix) begin
            r_state <= OPCODE;
            r_op    <= byte_in;
         end else if (r_state == OPCODE && opcode_ready)
            r_state <= EXEC;
         else if (r_state == EXEC && next_instruction)
            r_state <= COLLECT;
      end
   end
`ifdef REP_PREFIX_EN
   logic [1:0] r_rep;
   assign rep_prefix = r_rep;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_rep <= 2'b00;
      else if (w_clear)
         r_rep <= 2'b00;
      else if (w_accept && w_rep)
         r_rep <= {1'b1, byte_in[0]};
   end
`else
   assign rep_prefix = 2'b00;
`endif
endmodule
